// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter owning a shared WIDTH-bit register bank.
// Latency: request at edge k drives q/q_valid/gnt in cycle k+1; all outputs registered.
// Backpressure: none; losing requesters simply keep req high and compete at the next IDLE edge.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2,
  localparam int OW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [OW-1:0]         owner,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid
);

  // Counter holds "writes remaining after this one", so it only needs HOLD-1.
  localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [OW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [NREQ-1:0]    r_gnt;
  logic [OW-1:0]      r_owner;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_valid;

  state_t             w_state_nxt;
  logic [OW-1:0]      w_ptr_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [NREQ-1:0]    w_gnt_nxt;
  logic [OW-1:0]      w_owner_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_q_valid_nxt;

  logic               w_found;
  logic [OW-1:0]      w_win;

  // Round-robin search: first asserted request starting at r_ptr, wrapping.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = OW'(idx);
      end
    end
  end

  // Next-state and next-output decode; everything holds unless a case changes it.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_q_nxt       = r_q;
    w_q_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt   = S_GRANT;
          w_gnt_nxt     = NREQ'(1) << w_win;
          w_owner_nxt   = w_win;
          w_q_nxt       = din[w_win*WIDTH +: WIDTH];
          w_q_valid_nxt = 1'b1;
          w_cnt_nxt     = CW'(HOLD - 1);
        end
      end
      S_GRANT: begin
        if (req[r_owner] && (r_cnt != '0)) begin
          w_q_nxt       = din[r_owner*WIDTH +: WIDTH];
          w_q_valid_nxt = 1'b1;
          w_cnt_nxt     = r_cnt - CW'(1);
        end else begin
          // Release edge: no write here, and the pointer moves past the owner.
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State register; reset overrides any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign q       = r_q;
  assign q_valid = r_q_valid;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: HOLD=2 and HOLD=1 builds driven by the same stimulus.
// Each edge updates a grant-level reference model per build and compares all outputs.
// Directed scenarios first, then randomized requests, data and occasional resets.
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;

  logic [NREQ-1:0]  gnt_a, gnt_b;
  logic [1:0]       owner_a, owner_b;
  logic [WIDTH-1:0] q_a, q_b;
  logic             qv_a, qv_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(2)) u_dut_h2 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_a), .owner(owner_a), .q(q_a), .q_valid(qv_a)
  );

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(1)) u_dut_h1 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_b), .owner(owner_b), .q(q_b), .q_valid(qv_b)
  );

  // Reference model, one slot per build: index 0 is HOLD=2, index 1 is HOLD=1.
  int         m_hold  [2] = '{2, 1};
  bit         m_busy  [2];
  int         m_used  [2];
  int         m_ptr   [2];
  int         m_owner [2];
  logic [3:0] m_gnt   [2];
  logic [7:0] m_q     [2];
  bit         m_qv    [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] din_of(input int i);
    logic [NREQ*WIDTH-1:0] d;
    d = din;
    return d[i*WIDTH +: WIDTH];
  endfunction

  task automatic set_din(input int i, input logic [7:0] v);
    din[i*WIDTH +: WIDTH] = v;
  endtask

  // One rising edge of behaviour expressed as grants and write budgets.
  task automatic model_edge(input int h);
    int w;
    if (rst) begin
      m_busy[h] = 0; m_used[h] = 0; m_ptr[h] = 0; m_owner[h] = 0;
      m_gnt[h] = '0; m_q[h] = '0; m_qv[h] = 0;
    end else if (!m_busy[h]) begin
      m_qv[h] = 0;
      if (req != '0) begin
        w = m_ptr[h];
        while (!req[w]) w = (w + 1) % NREQ;
        m_busy[h] = 1; m_owner[h] = w; m_used[h] = 1;
        m_gnt[h] = 4'b0001 << w; m_q[h] = din_of(w); m_qv[h] = 1;
      end
    end else if (req[m_owner[h]] && m_used[h] < m_hold[h]) begin
      m_q[h] = din_of(m_owner[h]); m_qv[h] = 1; m_used[h]++;
    end else begin
      m_busy[h] = 0; m_gnt[h] = '0; m_qv[h] = 0;
      m_ptr[h] = (m_owner[h] + 1) % NREQ;
    end
  endtask

  // Advance one edge, update both models, sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("h2_gnt",   32'(gnt_a),   32'(m_gnt[0]));
    check("h2_owner", 32'(owner_a), 32'(m_owner[0]));
    check("h2_q",     32'(q_a),     32'(m_q[0]));
    check("h2_qv",    32'(qv_a),    32'(m_qv[0]));
    check("h1_gnt",   32'(gnt_b),   32'(m_gnt[1]));
    check("h1_owner", 32'(owner_b), 32'(m_owner[1]));
    check("h1_q",     32'(q_b),     32'(m_q[1]));
    check("h1_qv",    32'(qv_b),    32'(m_qv[1]));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    din = '1;
    #2;

    // Reset held for two edges with all requests high.
    repeat (2) begin
      step();
      check("rst_gnt", 32'(gnt_a), 32'h0);
      check("rst_q",   32'(q_a),   32'h0);
      check("rst_qv",  32'(qv_a),  32'h0);
    end

    // Single requester on HOLD=2 build.
    rst = 1'b0; req = 4'b0100; set_din(2, 8'hA5);
    step();
    check("single_gnt",   32'(gnt_a),   32'h4);
    check("single_owner", 32'(owner_a), 32'h2);
    check("single_q",     32'(q_a),     32'hA5);
    set_din(2, 8'h3C);
    step();
    check("single_q2", 32'(q_a), 32'h3C);
    step();
    check("single_rel_gnt", 32'(gnt_a), 32'h0);
    check("single_rel_qv",  32'(qv_a),  32'h0);
    check("single_rel_q",   32'(q_a),   32'h3C);
    step();
    check("single_regrant", 32'(gnt_a), 32'h4);
    req = '0;
    repeat (3) step();

    // Full contention: grant order 0,1,2,3,0 with 2-on/1-off rhythm.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_din(i, 8'(8'h10 + i));
    req = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      step();
      if (i % 3 == 0) check("contend_owner", 32'(owner_a), 32'((i / 3) % NREQ));
      check("contend_qv", 32'(qv_a), (i % 3 == 2) ? 32'h0 : 32'h1);
    end

    // Early release: owner 1 drops after one cycle, then 0 wins over 1.
    do_reset();
    req = 4'b0010;
    step();
    check("early_gnt", 32'(gnt_a), 32'h2);
    req = 4'b0000;
    step();
    check("early_rel_gnt", 32'(gnt_a), 32'h0);
    check("early_rel_q",   32'(q_a),   32'h11);
    req = 4'b0011;
    step();
    check("early_next_owner", 32'(owner_a), 32'h0);
    req = '0;
    repeat (3) step();

    // Reset in the middle of a grant.
    do_reset();
    req = 4'b0010;
    step();
    check("midrst_pre_gnt", 32'(gnt_a), 32'h2);
    rst = 1'b1;
    step();
    check("midrst_gnt",   32'(gnt_a),   32'h0);
    check("midrst_owner", 32'(owner_a), 32'h0);
    check("midrst_q",     32'(q_a),     32'h0);
    rst = 1'b0; req = 4'b1001;
    step();
    check("midrst_owner_after", 32'(owner_a), 32'h0);

    // HOLD=1 build under two-way contention.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step();
      case (i % 4)
        0: check("h1_alt", 32'(gnt_b), 32'h1);
        2: check("h1_alt", 32'(gnt_b), 32'h2);
        default: check("h1_alt", 32'(gnt_b), 32'h0);
      endcase
    end

    // Randomized traffic with held-request runs and rare resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      din = 32'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin write arbiter for a shared WIDTH-bit D flip-flop register bank. Up to NREQ requesters compete to load data into the bank. The winner owns the bank for up to HOLD consecutive clock-edge writes, then ownership rotates. The block contains the bank register itself, the arbitration pointer, the hold counter and a two-state controller.

## Interface
- NREQ, 4, number of requesters; legal range ≥ 2
- WIDTH, 8, bank data width in bits; legal range ≥ 1
- HOLD, 2, maximum writes per grant; legal range ≥ 1
- OW (localparam), max(1, $clog2(NREQ)), owner index width

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester write request; level-sensitive
- din  in  NREQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot ownership, registered; all-zero when no owner
- owner  out  OW  index of the current or most recent owner, registered
- q  out  WIDTH  shared bank contents, registered
- q_valid  out  1  high in the cycle after an edge at which q was loaded

## Operation
- Internal state:
  - FSM state: IDLE or GRANT
  - ptr (OW bits): round-robin start index
  - cnt: writes remaining, sized for HOLD-1
- Reset (rst=1 at an edge) overrides all other activity, including an in-progress grant. Resulting values:
  - state=IDLE, ptr=0, cnt=0
  - gnt=0, owner=0, q=0, q_valid=0
- Winner selection: the first index with req=1, searching ptr, ptr+1, … upward and wrapping modulo NREQ.
- IDLE, req=0 at the edge:
  - state stays IDLE, gnt=0, q_valid<=0
  - q, owner and ptr hold
- IDLE, at least one req=1 at the edge (winner w):
  - state<=GRANT, gnt<=onehot(w), owner<=w
  - q<=din[w], q_valid<=1, cnt<=HOLD-1
- GRANT, req[owner]=1 and cnt≠0 at the edge:
  - q<=din[owner], q_valid<=1, cnt<=cnt-1
  - gnt, owner and ptr hold
- GRANT, req[owner]=0 or cnt=0 at the edge (release):
  - state<=IDLE, gnt<=0, q_valid<=0
  - ptr<=(owner+1) mod NREQ
  - q and owner hold; no write occurs at this edge
- Requests from non-owners are ignored during GRANT. They are not queued; they compete at the next IDLE edge.
- ptr changes only on release, so a requester that holds req continuously is served within NREQ grants.
- Meaning of gnt[i]=1 in a cycle: requester i's din was captured at the preceding edge, and it is captured again at the current edge if req[i] stays high and the hold budget remains.

## Timing
- Arbitration latency: req high at edge k (state IDLE) produces q=din[w], q_valid=1 and gnt[w]=1 in cycle k+1.
- A grant with req held lasts HOLD cycles of gnt and produces HOLD writes, at edges k … k+HOLD-1.
- The release edge is k+HOLD. The IDLE edge k+HOLD+1 re-arbitrates.
- Sustained contention gives one grant every HOLD+1 cycles, with a one-cycle bubble (gnt=0, q_valid=0) between grants.
- An early release (owner drops req) costs one edge: the release edge performs no write.
- No combinational path from inputs to outputs.
- q changes only on edges where q_valid is being set to 1.

## Test plan
- Reset: hold rst=1 for 2 edges with req=4'b1111 and all din=8'hFF → gnt=0, owner=0, q=8'h00, q_valid=0 after each edge.
- Single requester (HOLD=2): req=4'b0100, din[2]=8'hA5, held high from edge k.
  - After k: gnt=4'b0100, owner=2, q=8'hA5, q_valid=1.
  - Change din[2] to 8'h3C before k+1; after k+1: q=8'h3C.
  - After k+2: gnt=0, q_valid=0, q=8'h3C.
  - After k+3: re-granted to 2 (ptr=3 wraps).
- Full contention (HOLD=2): req=4'b1111 held, distinct din → grant order 0,1,2,3,0.
  - Each gnt lasts 2 cycles, followed by one gnt=0 cycle; q_valid pattern 1,1,0 repeating.
- Early release: req[1] high only for one cycle, granted at edge k → at k+1 release.
  - gnt=0, q_valid=0, q holds din[1] from k, ptr=2.
  - Next arbitration with req=4'b0011 grants 0 (search 2,3,0).
- Reset mid-grant: assert rst while gnt=4'b0010 → after that edge all outputs are at reset values.
  - Then req=4'b1001 grants requester 0 (ptr reset to 0).
- HOLD=1 build: req=4'b0011 held → gnt alternates 0001, 0000, 0010, 0000, …; each grant performs exactly one write.
